// File: rtl/bf_pkg.sv
// Shared types and field layout for the Bellman-Ford engine.
// Edge word is {src, dst, weight}; work record is {dist, pred}.
package bf_pkg;

  typedef enum logic [3:0] {
    IDLE, INIT, EDGE_RD, DIST_RD, RELAX, PASS_END, CHECK, OUTPUT, DONE
  } bfState_t;

  localparam int EDGE_WEIGHT_LSB = 0;
  localparam int REC_PRED_LSB    = 0;

  function automatic int edgeDstLsb(input int weightW);
    return weightW;
  endfunction

  function automatic int edgeSrcLsb(input int nodeW, input int weightW);
    return nodeW + weightW;
  endfunction

  function automatic int recDistLsb(input int nodeW);
    return nodeW;
  endfunction

  // Largest positive distance doubles as "unreached".
  function automatic longint infDist(input int distW);
    return (longint'(1) << (distW - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/bf_relax_unit.sv
// Combinational relax step: sum = ds + sext(w) in DIST_W+1 bits, update when it improves dd.
// Zero latency; no flow control.
module bf_relax_unit
  import bf_pkg::*;
#(
  parameter int DIST_W   = 17,
  parameter int WEIGHT_W = 8
) (
  input  logic [DIST_W-1:0]   distSrc,
  input  logic [DIST_W-1:0]   distDst,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                update,
  output logic [DIST_W-1:0]   sum
);

  localparam logic [DIST_W-1:0] INF = DIST_W'(infDist(DIST_W));

  logic signed [DIST_W:0] srcExt, dstExt, wExt, sumWide, infWide;

  assign srcExt  = {distSrc[DIST_W-1], distSrc};
  assign dstExt  = {distDst[DIST_W-1], distDst};
  assign wExt    = {{(DIST_W + 1 - WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
  assign infWide = {1'b0, INF};
  assign sumWide = srcExt + wExt;

  // The extra bit keeps the sum from wrapping past INF before the compare.
  assign update = (distSrc != INF) && (sumWide < dstExt) && (sumWide < infWide);
  assign sum    = sumWide[DIST_W-1:0];

endmodule

// File: rtl/bf_engine_param.sv
// Bellman-Ford controller: init, edge relax passes, negative-cycle check pass, result streaming.
// Latency 1 + N + P*(3E+1) + (N+1) + 1 cycles; start is ignored while busy.
module bf_engine_param
  import bf_pkg::*;
#(
  parameter int NODE_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int DIST_W   = 17,
  parameter int EDGE_AW  = 13
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NODE_W:0]            num_nodes,
  input  logic [EDGE_AW:0]           num_edges,
  input  logic [NODE_W-1:0]          src_node,
  output logic [EDGE_AW-1:0]         edge_addr,
  input  logic [2*NODE_W+WEIGHT_W-1:0] edge_data,
  output logic [NODE_W-1:0]          work_rd_addr0,
  output logic [NODE_W-1:0]          work_rd_addr1,
  input  logic [DIST_W+NODE_W-1:0]   work_rd_data0,
  input  logic [DIST_W+NODE_W-1:0]   work_rd_data1,
  output logic [NODE_W-1:0]          work_wr_addr,
  output logic [DIST_W+NODE_W-1:0]   work_wr_data,
  output logic                       work_we,
  output logic [NODE_W-1:0]          out_addr,
  output logic [DIST_W+NODE_W-1:0]   out_data,
  output logic                       out_we,
  output logic                       busy,
  output logic                       done,
  output logic                       neg_cycle,
  output logic [NODE_W:0]            pass_count
);

  localparam int EDGE_W = 2 * NODE_W + WEIGHT_W;
  localparam int E_SRC  = edgeSrcLsb(NODE_W, WEIGHT_W);
  localparam int E_DST  = edgeDstLsb(WEIGHT_W);
  localparam int R_DIST = recDistLsb(NODE_W);
  localparam logic [DIST_W-1:0] INF = DIST_W'(infDist(DIST_W));
  localparam logic [NODE_W:0]   NODE_ONE = (NODE_W + 1)'(1);
  localparam logic [EDGE_AW:0]  EDGE_ONE = (EDGE_AW + 1)'(1);

  bfState_t state, nextState;

  logic [NODE_W:0]    nNodes, nodeIdx, passCount;
  logic [EDGE_AW:0]   nEdges, edgeIdx;
  logic [NODE_W-1:0]  srcNode, outAddrReg;
  logic [EDGE_W-1:0]  edgeReg;
  logic               passUpdated, checkMode, outVld, negCycle;

  logic               lastNode, lastEdge, relaxUpdate;
  logic [DIST_W-1:0]  relaxSum;
  logic [NODE_W-1:0]  eSrc, eDst, unusedPred0;

  assign lastNode    = (nodeIdx == nNodes - NODE_ONE);
  assign lastEdge    = (edgeIdx == nEdges - EDGE_ONE);
  assign eSrc        = edgeReg[E_SRC +: NODE_W];
  assign eDst        = edgeReg[E_DST +: NODE_W];
  assign unusedPred0 = work_rd_data0[REC_PRED_LSB +: NODE_W];

  bf_relax_unit #(
    .DIST_W   (DIST_W),
    .WEIGHT_W (WEIGHT_W)
  ) uRelax (
    .distSrc (work_rd_data0[R_DIST +: DIST_W]),
    .distDst (work_rd_data1[R_DIST +: DIST_W]),
    .weight  (edgeReg[EDGE_WEIGHT_LSB +: WEIGHT_W]),
    .update  (relaxUpdate),
    .sum     (relaxSum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      nNodes      <= '0;
      nEdges      <= '0;
      srcNode     <= '0;
      nodeIdx     <= '0;
      edgeIdx     <= '0;
      edgeReg     <= '0;
      passUpdated <= 1'b0;
      checkMode   <= 1'b0;
      outVld      <= 1'b0;
      outAddrReg  <= '0;
      negCycle    <= 1'b0;
      passCount   <= '0;
    end else begin
      state      <= nextState;
      outVld     <= (state == OUTPUT) && (nodeIdx < nNodes);
      outAddrReg <= nodeIdx[NODE_W-1:0];
      case (state)
        IDLE: if (start) begin
          nNodes      <= num_nodes;
          nEdges      <= num_edges;
          srcNode     <= src_node;
          nodeIdx     <= '0;
          edgeIdx     <= '0;
          passUpdated <= 1'b0;
          checkMode   <= 1'b0;
          negCycle    <= 1'b0;
          passCount   <= '0;
        end
        INIT:    nodeIdx <= lastNode ? '0 : nodeIdx + NODE_ONE;
        DIST_RD: edgeReg <= edge_data;
        RELAX: begin
          if (relaxUpdate) begin
            if (checkMode) negCycle <= 1'b1;
            else           passUpdated <= 1'b1;
          end
          edgeIdx <= lastEdge ? '0 : edgeIdx + EDGE_ONE;
        end
        PASS_END: begin
          passCount   <= passCount + NODE_ONE;
          passUpdated <= 1'b0;
        end
        CHECK:   checkMode <= 1'b1;
        OUTPUT:  nodeIdx   <= nodeIdx + NODE_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (start) nextState = (num_nodes == '0) ? DONE : INIT;
      INIT:     if (lastNode) nextState = (nEdges == '0) ? OUTPUT : EDGE_RD;
      EDGE_RD:  nextState = DIST_RD;
      DIST_RD:  nextState = RELAX;
      RELAX:    if (lastEdge) nextState = checkMode ? OUTPUT : PASS_END;
                else          nextState = EDGE_RD;
      PASS_END: begin
        if (!passUpdated)                                nextState = OUTPUT;
        else if (passCount + NODE_ONE >= nNodes - NODE_ONE) nextState = CHECK;
        else                                             nextState = EDGE_RD;
      end
      CHECK:    nextState = EDGE_RD;
      OUTPUT:   if (nodeIdx == nNodes) nextState = DONE;
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    edge_addr     = '0;
    work_rd_addr0 = '0;
    work_rd_addr1 = '0;
    work_wr_addr  = '0;
    work_wr_data  = '0;
    work_we       = 1'b0;
    case (state)
      INIT: begin
        work_wr_addr = nodeIdx[NODE_W-1:0];
        work_wr_data = {(nodeIdx[NODE_W-1:0] == srcNode) ? '0 : INF, nodeIdx[NODE_W-1:0]};
        work_we      = !reset;
      end
      EDGE_RD: edge_addr = edgeIdx[EDGE_AW-1:0];
      DIST_RD: begin
        work_rd_addr0 = edge_data[E_SRC +: NODE_W];
        work_rd_addr1 = edge_data[E_DST +: NODE_W];
      end
      RELAX: begin
        work_wr_addr = eDst;
        work_wr_data = {relaxSum, eSrc};
        // The check pass only observes; a write here would corrupt results.
        work_we      = relaxUpdate && !checkMode && !reset;
      end
      OUTPUT:  work_rd_addr1 = nodeIdx[NODE_W-1:0];
      default: ;
    endcase
  end

  assign out_addr   = outVld ? outAddrReg : '0;
  assign out_data   = outVld ? {work_rd_data1[REC_PRED_LSB +: NODE_W],
                                work_rd_data1[R_DIST +: DIST_W]} : '0;
  assign out_we     = outVld && !reset;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign neg_cycle  = negCycle;
  assign pass_count = passCount;

endmodule

// File: tb/tb_bf_engine_param.sv
// Directed bench for bf_engine_param with behavioural edge/work/output memories.
module tb_bf_engine_param;

  localparam int NODE_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int DIST_W   = 17;
  localparam int EDGE_AW  = 13;
  localparam int EDGE_W   = 2 * NODE_W + WEIGHT_W;
  localparam int REC_W    = DIST_W + NODE_W;
  localparam int INF      = 65535;

  logic                clock = 1'b0;
  logic                reset, start;
  logic [NODE_W:0]     num_nodes;
  logic [EDGE_AW:0]    num_edges;
  logic [NODE_W-1:0]   src_node;
  logic [EDGE_AW-1:0]  edge_addr;
  logic [EDGE_W-1:0]   edge_data;
  logic [NODE_W-1:0]   work_rd_addr0, work_rd_addr1, work_wr_addr, out_addr;
  logic [REC_W-1:0]    work_rd_data0, work_rd_data1, work_wr_data, out_data;
  logic                work_we, out_we, busy, done, neg_cycle;
  logic [NODE_W:0]     pass_count;

  logic [EDGE_W-1:0]   edgeMem [0:15];
  logic [REC_W-1:0]    workMem [0:255];
  logic [REC_W-1:0]    outMem  [0:255];

  int nAsserts = 0;
  int nFails   = 0;
  int weCount = 0, outWeCount = 0, doneCount = 0;
  int runCycles, weBefore, outBefore, doneBefore;
  logic runTimeout, busyFirst, negFirst;

  always #5 clock = ~clock;

  bf_engine_param #(
    .NODE_W(NODE_W), .WEIGHT_W(WEIGHT_W), .DIST_W(DIST_W), .EDGE_AW(EDGE_AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .num_nodes(num_nodes), .num_edges(num_edges), .src_node(src_node),
    .edge_addr(edge_addr), .edge_data(edge_data),
    .work_rd_addr0(work_rd_addr0), .work_rd_addr1(work_rd_addr1),
    .work_rd_data0(work_rd_data0), .work_rd_data1(work_rd_data1),
    .work_wr_addr(work_wr_addr), .work_wr_data(work_wr_data), .work_we(work_we),
    .out_addr(out_addr), .out_data(out_data), .out_we(out_we),
    .busy(busy), .done(done), .neg_cycle(neg_cycle), .pass_count(pass_count)
  );

  always @(posedge clock) begin
    edge_data     <= edgeMem[edge_addr[3:0]];
    work_rd_data0 <= workMem[work_rd_addr0];
    work_rd_data1 <= workMem[work_rd_addr1];
    if (work_we) workMem[work_wr_addr] <= work_wr_data;
    if (out_we)  outMem[out_addr]      <= out_data;
  end

  always @(posedge clock) begin
    if (work_we) weCount++;
    if (out_we)  outWeCount++;
    if (done)    doneCount++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkNode(input string tag, input int i, input int d, input int p);
    logic [REC_W-1:0] r;
    r = outMem[i];
    chk($sformatf("%s_dist%0d", tag, i), $signed(r[DIST_W-1:0]), d);
    chk($sformatf("%s_pred%0d", tag, i), r[DIST_W +: NODE_W], p);
  endtask

  task automatic setEdge(input int idx, input int s, input int d, input int w);
    edgeMem[idx] = {8'(s), 8'(d), 8'(w)};
  endtask

  // Starts a run in the first idle cycle; runCycles counts the start cycle through the done cycle.
  task automatic runBf(input int n, input int e, input int s, input int extraAt);
    @(posedge clock);
    @(negedge clock);
    weBefore   = weCount;
    outBefore  = outWeCount;
    doneBefore = doneCount;
    num_nodes  = 9'(n);
    num_edges  = 14'(e);
    src_node   = 8'(s);
    start      = 1'b1;
    runCycles  = 1;
    runTimeout = 1'b1;
    for (int k = 1; k < 5000; k++) begin
      @(posedge clock);
      #1;
      runCycles++;
      if (k == 1) begin
        busyFirst = busy;
        negFirst  = neg_cycle;
      end
      start     = (k == extraAt);
      num_nodes = (k == extraAt) ? 9'd2 : 9'(n);
      if (done) begin
        runTimeout = 1'b0;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chainEdges();
    setEdge(0, 0, 1, 5);
    setEdge(1, 1, 2, 3);
    setEdge(2, 2, 3, -2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    num_nodes = '0; num_edges = '0; src_node = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_work_we", work_we, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_neg", neg_cycle, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_edge_addr", edge_addr, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_no_write", weCount, 0);

    // Chain
    chainEdges();
    runBf(4, 3, 0, -1);
    chk("s1_timeout", runTimeout, 0);
    chk("s1_busy", busyFirst, 1);
    chk("s1_latency", runCycles, 31);
    chk("s1_pass", pass_count, 2);
    chk("s1_neg", neg_cycle, 0);
    chk("s1_outwe", outWeCount - outBefore, 4);
    chk("s1_done_once", doneCount - doneBefore, 1);
    chkNode("s1", 0, 0, 0);
    chkNode("s1", 1, 5, 0);
    chkNode("s1", 2, 8, 1);
    chkNode("s1", 3, 6, 2);

    // Negative cycle 1 <-> 2
    setEdge(0, 0, 1, 1);
    setEdge(1, 1, 2, -1);
    setEdge(2, 2, 1, -1);
    runBf(3, 3, 0, -1);
    chk("s2_timeout", runTimeout, 0);
    chk("s2_neg", neg_cycle, 1);
    chk("s2_pass", pass_count, 2);
    chk("s2_writes", weCount - weBefore, 8);
    chk("s2_outwe", outWeCount - outBefore, 3);

    // Back-to-back run with an ignored start mid-run
    chainEdges();
    runBf(4, 3, 0, 5);
    chk("s6_timeout", runTimeout, 0);
    chk("s6_neg_cleared", negFirst, 0);
    chk("s6_latency", runCycles, 31);
    chk("s6_neg", neg_cycle, 0);
    chk("s6_pass", pass_count, 2);
    chk("s6_done_once", doneCount - doneBefore, 1);
    chkNode("s6", 0, 0, 0);
    chkNode("s6", 1, 5, 0);
    chkNode("s6", 2, 8, 1);
    chkNode("s6", 3, 6, 2);

    // Unreachable node
    setEdge(0, 0, 1, 4);
    runBf(3, 1, 0, -1);
    chk("s3_timeout", runTimeout, 0);
    chk("s3_latency", runCycles, 17);
    chk("s3_pass", pass_count, 2);
    chkNode("s3", 0, 0, 0);
    chkNode("s3", 1, 4, 0);
    chkNode("s3", 2, INF, 2);

    // No edges
    runBf(5, 0, 3, -1);
    chk("s4_timeout", runTimeout, 0);
    chk("s4_latency", runCycles, 13);
    chk("s4_pass", pass_count, 0);
    chk("s4_outwe", outWeCount - outBefore, 5);
    for (int i = 0; i < 5; i++) chkNode("s4", i, (i == 3) ? 0 : INF, i);

    // No nodes
    runBf(0, 2, 0, -1);
    chk("n0_timeout", runTimeout, 0);
    chk("n0_latency", runCycles, 2);
    chk("n0_writes", weCount - weBefore, 0);
    chk("n0_outwe", outWeCount - outBefore, 0);

    // Reset in the first RELAX cycle (edge 0->1 update pending)
    chainEdges();
    @(negedge clock);
    num_nodes = 9'd4; num_edges = 14'd3; src_node = 8'd0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("s5_we_pending", work_we, 1);
    weBefore   = weCount;
    doneBefore = doneCount;
    reset = 1'b1;
    #1;
    chk("s5_we_in_reset", work_we, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("s5_we_after", work_we, 0);
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("s5_no_writes", weCount - weBefore, 0);
    chk("s5_no_done", doneCount - doneBefore, 0);
    runBf(4, 3, 0, -1);
    chk("s5r_timeout", runTimeout, 0);
    chk("s5r_latency", runCycles, 31);
    chk("s5r_pass", pass_count, 2);
    chk("s5r_neg", neg_cycle, 0);
    chkNode("s5r", 0, 0, 0);
    chkNode("s5r", 1, 5, 0);
    chkNode("s5r", 2, 8, 1);
    chkNode("s5r", 3, 6, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/bf_engine_param.md
Name: bf_engine_param

Overview:
- Parametrised Bellman-Ford single-source shortest-path engine; next generation of the fixed-width top-level controller/datapath pair.
- Walks an external edge-list memory and relaxes distances held in an external work memory.
- Stops early when a pass makes no update, runs one extra check pass to flag negative cycles, then streams {pred, dist} per node to an output memory.
- All memories sit outside the block; synchronous-read, 1-cycle latency.

Parameters:
NODE_W, 8, node index width (max 2^NODE_W nodes)
WEIGHT_W, 8, signed edge weight width
DIST_W, 17, signed distance width; INF = 2^(DIST_W-1)-1
EDGE_AW, 13, edge memory address width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
start  in  1  run request, sampled in IDLE only
num_nodes  in  NODE_W+1  node count, latched on start
num_edges  in  EDGE_AW+1  edge count, latched on start
src_node  in  NODE_W  source node, latched on start
edge_addr  out  EDGE_AW  edge memory read address
edge_data  in  2*NODE_W+WEIGHT_W  {src, dst, weight}, valid 1 cycle after edge_addr
work_rd_addr0  out  NODE_W  work read port 0 (edge src)
work_rd_addr1  out  NODE_W  work read port 1 (edge dst / output scan)
work_rd_data0  in  DIST_W+NODE_W  {dist, pred}
work_rd_data1  in  DIST_W+NODE_W  {dist, pred}
work_wr_addr  out  NODE_W  work write address
work_wr_data  out  DIST_W+NODE_W  {dist, pred}
work_we  out  1  work write enable
out_addr  out  NODE_W  output memory address
out_data  out  DIST_W+NODE_W  {pred, dist}
out_we  out  1  output write enable
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of run
neg_cycle  out  1  result flag; held until next accepted start
pass_count  out  NODE_W+1  passes executed, excluding the check pass

Behaviour:
- Reset: FSM to IDLE; every output 0; no memory write in the reset cycle or the cycle after it.
- Reset mid-run: run aborts immediately, no completion pulse. Memory contents are not restored.
- IDLE: start=1 latches inputs, clears neg_cycle and pass_count. start while busy is ignored.
- num_nodes=0: go straight to DONE (done pulse next cycle, no writes).
- INIT: one node per cycle, i = 0..num_nodes-1. Write dist=INF, pred=i; for i==src_node write dist=0, pred=src_node.
- Per-edge sequence, 3 cycles, no overlap:
  - EDGE_RD: drive edge_addr=e.
  - DIST_RD: drive work_rd_addr0=src, work_rd_addr1=dst from edge_data.
  - RELAX: sum = ds + sext(w), computed in DIST_W+1 bits.
- Update condition: ds != INF, and sum < dd, and sum < INF. Update writes {sum, src} to dst in the same cycle and sets pass_updated.
- Self-loops are legal. Both read ports at the same address is legal.
- PASS_END: pass_count++.
  - pass_updated=0 → OUTPUT.
  - Otherwise, if pass_count == num_nodes-1 → CHECK.
  - Otherwise start a new pass at e=0.
- num_edges=0: skip passes entirely, pass_count stays 0.
- CHECK: same edge walk, work_we held 0. Any met update condition sets neg_cycle=1; distances stay unmodified.
- OUTPUT: pipelined, 1 node/cycle. Read at i on port 1; next cycle out_addr=i, out_data={pred, dist}, out_we=1. Total num_nodes+1 cycles.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency, no negative cycle: 1 + N + P·(3E+1) + (N+1) + 1 cycles, where N=num_nodes, E=num_edges, P=passes.

Decomposition:
- Shared package bf_pkg holds:
  - state enum (IDLE, INIT, EDGE_RD, DIST_RD, RELAX, PASS_END, CHECK, OUTPUT, DONE);
  - edge field slice offsets;
  - INF constant function of DIST_W;
  - record field offsets for {dist, pred}.
- One sub-module, bf_relax_unit: combinational sign-extend/add/compare, producing update and sum.
- FSM, counters and memory port muxing stay in bf_engine_param.

Test Plan:
1. Chain, N=4, source 0: edges 0→1(5), 1→2(3), 2→3(-2) → out dist {0,5,8,6}, pred {0,0,1,2}, neg_cycle=0, pass_count=2.
2. Negative cycle, N=3: edges 0→1(1), 1→2(-1), 2→1(-1) → neg_cycle=1, pass_count=2, no work_we during CHECK.
3. Unreachable node, N=3, edge 0→1(4) only → node 2 dist=65535, pred=2; node 1 dist=4, pred=0.
4. num_edges=0, N=5, source 3 → dist {INF,INF,INF,0,INF}, pass_count=0, done pulses exactly 2N+3 cycles after start.
5. reset asserted in a RELAX cycle with update pending → work_we=0 that cycle and the next, busy=0, done=0; rerun of scenario 1 gives the same results.
6. start pulsed while busy, then back-to-back runs → second start ignored; the next run clears neg_cycle left from scenario 2 and produces correct output.
